apb_cmd_master: RTL and testbench

- Upstream APB requester that turns a simple valid/ready command stream (write/read, address, data) into single APB3 transfers to the example register slave.
- Returns one response per command (read data plus error flag) on a valid/ready response channel.
- Sits between the test or CPU-side command source and the APB interface of the register block.
- One transfer in flight at a time. Misaligned addresses are rejected locally.

---
 rtl/apb_cmd_master_if.sv | 44 ++++
 rtl/apb_cmd_master.sv | 98 +++++++++
 tb/tb_apb_cmd_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB3 signals of the APB command master.
// The master modport is the requester's view; slave is the command source / APB target side.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 requester: one valid/ready command becomes one APB transfer and one response.
// Optional ACCESS wait timeout is enabled with `define APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic pclk,
    input  logic rst_n,
    apb_cmd_master_if.master bus
);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
    localparam logic [DATA_W-1:0] ZERO_DATA = '0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    logic [3:0] wait_cnt;
`endif

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= ZERO_DATA;
            bus.rsp_err   <= 1'b0;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= ZERO_ADDR;
            bus.pwdata    <= ZERO_DATA;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            wait_cnt      <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        if (bus.cmd_addr[1:0] == 2'b00) begin
                            bus.paddr  <= bus.cmd_addr;
                            bus.pwrite <= bus.cmd_write;
                            bus.pwdata <= bus.cmd_wdata;
                            bus.psel   <= 1'b1;
                            state      <= SETUP;
                        end else begin
                            // Misaligned: answer locally without touching the bus.
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= ZERO_DATA;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    state       <= ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    wait_cnt    <= 4'd0;
`endif
                end
                ACCESS: begin
                    if (bus.pready) begin
                        bus.psel      <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.rsp_rdata <= (bus.pwrite || bus.pslverr) ? ZERO_DATA : bus.prdata;
                        bus.rsp_err   <= bus.pslverr;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    else if (wait_cnt == 4'd15) begin
                        bus.psel      <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.rsp_rdata <= ZERO_DATA;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small register-slave model on the APB side.
module tb_apb_cmd_master;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic pclk = 1'b0;
    logic rst_n;
    always #5 pclk = ~pclk;

    apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic        mdl_clr;
    logic        mdl_ready;
    logic        mdl_err;
    logic [31:0] r104;
    logic [31:0] r110;

    always @(posedge pclk) cyc <= cyc + 1;

    // Slave model: two writable registers, one ID register, one constant register.
    always @(posedge pclk) begin
        if (mdl_clr) begin
            r104 <= 32'h0;
            r110 <= 32'h0;
        end else if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
            if (bus.paddr == 16'h0104) r104 <= bus.pwdata;
            else if (bus.paddr == 16'h0110) r110 <= bus.pwdata;
        end
    end

    always_comb begin
        bus.prdata = 32'h0;
        case (bus.paddr)
            16'h0100: bus.prdata = 32'h01765A03;
            16'h0104: bus.prdata = r104;
            16'h0110: bus.prdata = r110;
            16'h0114: bus.prdata = 32'hCAFE0114;
            default:  bus.prdata = 32'h0;
        endcase
    end

    assign bus.pready  = mdl_ready;
    assign bus.pslverr = mdl_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         output int acc);
        logic hs;
        bit   done;
        done = 1'b0;
        acc  = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            hs = bus.cmd_ready;
            tick();
            if (hs) begin
                done = 1'b1;
                acc  = cyc;
            end
        end
        bus.cmd_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
        lat = 0;
        while (lat < 40 && !bus.rsp_valid) begin
            tick();
            lat++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    int          acc1, acc2, lat, ps, pe, first;
    logic [31:0] rd;
    logic        er;

    initial begin
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 16'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        mdl_clr   = 1'b1;
        mdl_ready = 1'b1;
        mdl_err   = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        rst_n   = 1'b1;
        mdl_clr = 1'b0;
        tick();
        check("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Read of the ID register with a zero-wait slave.
        issue(1'b0, 16'h0100, 32'h0, acc1);
        check("setup_cmd_ready", bus.cmd_ready, 0);
        ps = 0; pe = 0; first = 0;
        for (int k = 1; k <= 5; k++) begin
            ps += int'(bus.psel);
            pe += int'(bus.penable);
            if (bus.rsp_valid && first == 0) first = k;
            if (k < 5) tick();
        end
        check("rd100_psel_cycles", ps, 2);
        check("rd100_penable_cycles", pe, 1);
        check("rd100_rsp_latency", first, 3);
        check("rd100_rdata", bus.rsp_rdata, 32'h01765A03);
        check("rd100_err", bus.rsp_err, 0);
        consume();
        check("rd100_rsp_dropped", bus.rsp_valid, 0);

        // Write then read back, measuring command spacing.
        issue(1'b1, 16'h0104, 32'hDEADBEEF, acc1);
        wait_rsp(rd, er, lat);
        check("wr104_latency", lat, 2);
        check("wr104_rdata", rd, 32'h0);
        check("wr104_err", er, 0);
        consume();
        issue(1'b0, 16'h0104, 32'h0, acc2);
        check("cmd_spacing", acc2 - acc1, 4);
        wait_rsp(rd, er, lat);
        check("rd104_rdata", rd, 32'hDEADBEEF);
        check("rd104_err", er, 0);
        consume();

        // Misaligned read never reaches the bus.
        issue(1'b0, 16'h0102, 32'h0, acc1);
        check("mis_rsp_valid", bus.rsp_valid, 1);
        check("mis_psel", bus.psel, 0);
        check("mis_rdata", bus.rsp_rdata, 32'h0);
        check("mis_err", bus.rsp_err, 1);
        tick();
        check("mis_psel_later", bus.psel, 0);
        consume();

        // Wait states and response back-pressure.
        mdl_ready = 1'b0;
        issue(1'b0, 16'h0114, 32'h0, acc1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wait_psel", bus.psel, 1);
            check("wait_penable", bus.penable, 1);
            check("wait_paddr", bus.paddr, 32'h0114);
            check("wait_pwrite", bus.pwrite, 0);
            check("wait_rsp_valid", bus.rsp_valid, 0);
            tick();
        end
        mdl_ready = 1'b1;
        tick();
        check("wait_rsp_valid_set", bus.rsp_valid, 1);
        check("wait_rdata", bus.rsp_rdata, 32'hCAFE0114);
        check("wait_psel_dropped", bus.psel, 0);
        tick();
        tick();
        check("hold_rsp_valid", bus.rsp_valid, 1);
        check("hold_rdata", bus.rsp_rdata, 32'hCAFE0114);
        check("hold_err", bus.rsp_err, 0);
        consume();
        check("hold_rsp_dropped", bus.rsp_valid, 0);

        // Reset during ACCESS of a write discards it.
        mdl_ready = 1'b0;
        issue(1'b1, 16'h0110, 32'h55AA55AA, acc1);
        tick();
        check("abort_penable_before", bus.penable, 1);
        rst_n = 1'b0;
        tick();
        check("abort_psel", bus.psel, 0);
        check("abort_penable", bus.penable, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_cmd_ready", bus.cmd_ready, 0);
        rst_n = 1'b1;
        mdl_ready = 1'b1;
        repeat (3) tick();
        check("abort_no_rsp", bus.rsp_valid, 0);
        check("abort_cmd_ready_back", bus.cmd_ready, 1);
        issue(1'b0, 16'h0110, 32'h0, acc1);
        wait_rsp(rd, er, lat);
        check("abort_rd110", rd, 32'h0);
        check("abort_rd110_err", er, 0);
        consume();

        // Slave error is reported.
        mdl_err = 1'b1;
        issue(1'b1, 16'h0104, 32'h1, acc1);
        wait_rsp(rd, er, lat);
        check("slverr_err", er, 1);
        check("slverr_rdata", rd, 32'h0);
        mdl_err = 1'b0;
        consume();

        // Slave that never becomes ready.
        mdl_ready = 1'b0;
        issue(1'b0, 16'h0100, 32'h0, acc1);
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        wait_rsp(rd, er, lat);
        check("timeout_err", er, 1);
        check("timeout_rdata", rd, 32'h0);
        check("timeout_min_wait", (lat >= 16), 1);
        check("timeout_psel", bus.psel, 0);
        consume();
        mdl_ready = 1'b1;
        tick();
        check("timeout_cmd_ready", bus.cmd_ready, 1);
`else
        repeat (30) tick();
        check("stuck_penable", bus.penable, 1);
        check("stuck_rsp_valid", bus.rsp_valid, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mdl_ready = 1'b1;
        tick();
        check("stuck_recover_cmd_ready", bus.cmd_ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
